// File: rtl/haar_pkg.sv
// Shared types and helpers for the Haar cascade sequencer.
// Holds the FSM state type, the stage header layout and a saturating adder.
package haar_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StRdThr,
    StFeatReq,
    StDecide,
    StOut
  } haar_state_e;

  localparam int unsigned CNT_OFS   = 0;
  localparam int unsigned THR_OFS   = 1;
  localparam int unsigned HDR_WORDS = 2;

  // Signed add clamped to the range of a width-bit two's complement value (width <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/haar_cascade_sequencer_rom_reader.sv
// Single-word classifier ROM read: strobes rom_rd once, waits LATENCY cycles,
// then presents the returned word together with a one-cycle done pulse.
module haar_rom_reader
  import haar_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  done
);

  logic       busy_q, busy_d;
  logic [2:0] lat_q, lat_d;

  always_comb begin
    rom_rd   = start && !busy_q;
    rom_addr = rom_rd ? addr : '0;
    done     = busy_q && (lat_q == 3'(LATENCY));
    data     = rom_data;
    busy_d   = busy_q;
    lat_d    = lat_q;
    if (rom_rd) begin
      busy_d = 1'b1;
      lat_d  = 3'd1;
    end else if (done) begin
      busy_d = 1'b0;
      lat_d  = 3'd0;
    end else if (busy_q) begin
      lat_d = lat_q + 3'd1;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      busy_q <= 1'b0;
      lat_q  <= 3'd0;
    end else begin
      busy_q <= busy_d;
      lat_q  <= lat_d;
    end
  end

endmodule

// File: rtl/haar_cascade_sequencer.sv
// Multi-stage Haar cascade controller: walks the stage headers in the classifier ROM,
// requests one vote per weak classifier and emits windows that pass every stage.
// Optional REJECT_REPORT_EN adds cand_pass/cand_exit_stage and reports rejected windows too.
module haar_cascade_sequencer
  import haar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_12            = 12,
  parameter int unsigned DATA_WIDTH_16            = 16,
  parameter int unsigned SCALE_WIDTH              = 4,
  parameter int unsigned NUM_STAGES               = 3,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int unsigned ROM_ADDR_WIDTH           = 12,
  parameter int unsigned ROM_LATENCY              = 1,
  parameter int unsigned ACC_WIDTH                = 24
) (
  input  logic                      clk_fpga,
  input  logic                      reset_fpga,
  input  logic                      win_valid,
  output logic                      win_ready,
  input  logic [DATA_WIDTH_12-1:0]  win_xcoord,
  input  logic [DATA_WIDTH_12-1:0]  win_ycoord,
  input  logic [SCALE_WIDTH-1:0]    win_scale,
  output logic                      rom_rd,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH_16-1:0]  rom_data,
  output logic                      feat_req,
  output logic [ROM_ADDR_WIDTH-1:0] feat_addr,
  input  logic                      feat_ack,
  input  logic [DATA_WIDTH_16-1:0]  feat_vote,
  output logic                      cand_valid,
  input  logic                      cand_ready,
  output logic [DATA_WIDTH_12-1:0]  cand_xcoord,
  output logic [DATA_WIDTH_12-1:0]  cand_ycoord,
  output logic [SCALE_WIDTH-1:0]    cand_scale
`ifdef REJECT_REPORT_EN
  ,
  output logic                      cand_pass,
  output logic [7:0]                cand_exit_stage
`endif
);

  haar_state_e state_q, state_d;

  logic [DATA_WIDTH_12-1:0]         x_q, x_d, y_q, y_d;
  logic [SCALE_WIDTH-1:0]           scale_q, scale_d;
  logic [7:0]                       stage_q, stage_d;
  logic [ROM_ADDR_WIDTH-1:0]        base_q, base_d;
  logic [DATA_WIDTH_16-1:0]         cnt_q, cnt_d, idx_q, idx_d;
  logic signed [DATA_WIDTH_16-1:0]  thr_q, thr_d;
  logic signed [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic                             gap_q, gap_d;
`ifdef REJECT_REPORT_EN
  logic                             pass_q, pass_d;
  logic [7:0]                       exit_q, exit_d;
`endif

  logic                             rd_start, rd_done;
  logic [ROM_ADDR_WIDTH-1:0]        rd_addr;
  logic [DATA_WIDTH_16-1:0]         rd_data;
  logic [ROM_ADDR_WIDTH-1:0]        rec_addr, next_base;
  logic [DATA_WIDTH_16-1:0]         idx_inc;
  logic signed [63:0]               acc_sum;
  logic signed [ACC_WIDTH-1:0]      thr_ext;
  logic                             stage_pass, vote_take;

  haar_rom_reader #(
    .ADDR_WIDTH (ROM_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH_16),
    .LATENCY    (ROM_LATENCY)
  ) u_rom_reader (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .start      (rd_start),
    .addr       (rd_addr),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .data       (rd_data),
    .done       (rd_done)
  );

  // Record and next-stage addresses wrap modulo the ROM address space.
  always_comb begin
    rec_addr   = base_q + ROM_ADDR_WIDTH'(HDR_WORDS)
               + ROM_ADDR_WIDTH'(32'(idx_q) * NUM_PARAM_PER_CLASSIFIER);
    next_base  = base_q + ROM_ADDR_WIDTH'(HDR_WORDS)
               + ROM_ADDR_WIDTH'(32'(cnt_q) * NUM_PARAM_PER_CLASSIFIER);
    idx_inc    = idx_q + DATA_WIDTH_16'(1);
    acc_sum    = sat_add(64'(acc_q), 64'($signed(feat_vote)), ACC_WIDTH);
    thr_ext    = ACC_WIDTH'(thr_q);
    stage_pass = (acc_q >= thr_ext);
  end

  always_comb begin
    win_ready   = (state_q == StIdle);
    feat_req    = (state_q == StFeatReq) && !gap_q;
    feat_addr   = feat_req ? rec_addr : '0;
    vote_take   = feat_req && feat_ack;
    cand_valid  = (state_q == StOut);
    cand_xcoord = x_q;
    cand_ycoord = y_q;
    cand_scale  = scale_q;
`ifdef REJECT_REPORT_EN
    cand_pass       = pass_q;
    cand_exit_stage = exit_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    scale_d  = scale_q;
    stage_d  = stage_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    thr_d    = thr_q;
    acc_d    = acc_q;
    gap_d    = gap_q;
    rd_start = 1'b0;
    rd_addr  = base_q;
`ifdef REJECT_REPORT_EN
    pass_d   = pass_q;
    exit_d   = exit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          x_d     = win_xcoord;
          y_d     = win_ycoord;
          scale_d = win_scale;
          stage_d = 8'd0;
          base_d  = '0;
          state_d = StRdCnt;
        end
      end
      StRdCnt: begin
        rd_start = 1'b1;
        rd_addr  = base_q + ROM_ADDR_WIDTH'(CNT_OFS);
        if (rd_done) begin
          cnt_d   = rd_data;
          state_d = StRdThr;
        end
      end
      StRdThr: begin
        rd_start = 1'b1;
        rd_addr  = base_q + ROM_ADDR_WIDTH'(THR_OFS);
        if (rd_done) begin
          thr_d   = $signed(rd_data);
          acc_d   = '0;
          idx_d   = '0;
          gap_d   = 1'b0;
          state_d = (cnt_q != '0) ? StFeatReq : StDecide;
        end
      end
      StFeatReq: begin
        // A taken vote forces one idle cycle on feat_req before the next request.
        if (vote_take) begin
          acc_d = ACC_WIDTH'(acc_sum);
          idx_d = idx_inc;
          gap_d = 1'b1;
          if (idx_inc == cnt_q) begin
            state_d = StDecide;
          end
        end else if (gap_q) begin
          gap_d = 1'b0;
        end
      end
      StDecide: begin
        if (!stage_pass) begin
`ifdef REJECT_REPORT_EN
          pass_d  = 1'b0;
          exit_d  = stage_q;
          state_d = StOut;
`else
          state_d = StIdle;
`endif
        end else if (stage_q == 8'(NUM_STAGES - 1)) begin
`ifdef REJECT_REPORT_EN
          pass_d  = 1'b1;
          exit_d  = stage_q;
`endif
          state_d = StOut;
        end else begin
          stage_d = stage_q + 8'd1;
          base_d  = next_base;
          state_d = StRdCnt;
        end
      end
      StOut: begin
        if (cand_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      scale_q <= '0;
      stage_q <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      thr_q   <= '0;
      acc_q   <= '0;
      gap_q   <= 1'b0;
`ifdef REJECT_REPORT_EN
      pass_q  <= 1'b0;
      exit_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      scale_q <= scale_d;
      stage_q <= stage_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
`ifdef REJECT_REPORT_EN
      pass_q  <= pass_d;
      exit_q  <= exit_d;
`endif
    end
  end

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Directed bench for haar_cascade_sequencer: 3 stages, ROM latency 3, 16-bit accumulator.
module tb_haar_cascade_sequencer;

  localparam int unsigned AW   = 12;
  localparam int unsigned LAT  = 3;
  localparam int unsigned NST  = 3;
  localparam int unsigned ACCW = 16;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga;
  logic          win_valid, win_ready;
  logic [11:0]   win_xcoord, win_ycoord;
  logic [3:0]    win_scale;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          feat_req;
  logic [AW-1:0] feat_addr;
  logic          feat_ack;
  logic [15:0]   feat_vote;
  logic          cand_valid, cand_ready;
  logic [11:0]   cand_xcoord, cand_ycoord;
  logic [3:0]    cand_scale;
`ifdef REJECT_REPORT_EN
  logic          cand_pass;
  logic [7:0]    cand_exit_stage;
`endif

  always #5 clk_fpga = ~clk_fpga;

  haar_cascade_sequencer #(
    .NUM_STAGES  (NST),
    .ROM_LATENCY (LAT),
    .ACC_WIDTH   (ACCW)
  ) dut (
    .clk_fpga        (clk_fpga),
    .reset_fpga      (reset_fpga),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .win_xcoord      (win_xcoord),
    .win_ycoord      (win_ycoord),
    .win_scale       (win_scale),
    .rom_rd          (rom_rd),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .feat_req        (feat_req),
    .feat_addr       (feat_addr),
    .feat_ack        (feat_ack),
    .feat_vote       (feat_vote),
    .cand_valid      (cand_valid),
    .cand_ready      (cand_ready),
    .cand_xcoord     (cand_xcoord),
    .cand_ycoord     (cand_ycoord),
`ifdef REJECT_REPORT_EN
    .cand_pass       (cand_pass),
    .cand_exit_stage (cand_exit_stage),
`endif
    .cand_scale      (cand_scale)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ROM model: data is valid only in the single cycle LAT cycles after the strobe.
  logic [15:0]   rom [0:4095];
  logic [LAT-1:0] rd_pipe = '0;
  logic [AW-1:0] addr_pipe [LAT];
  int            rd_log[$];

  always @(posedge clk_fpga) begin
    rd_pipe      <= {rd_pipe[LAT-2:0], rom_rd};
    addr_pipe[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    if (rom_rd) rd_log.push_back(int'(rom_addr));
  end
  assign rom_data = rd_pipe[LAT-1] ? rom[addr_pipe[LAT-1]] : 16'hBAD0;

  // Feature evaluator model: answers queued votes after the queued per-vote delay.
  logic [15:0] vote_q[$];
  int          delay_q[$];
  int          feat_log[$];
  int          stale_req = 0;

  initial begin : responder
    int   wait_cnt;
    int   stale_seen;
    logic prev_ack;
    wait_cnt = 0; stale_seen = 0; prev_ack = 1'b0;
    feat_ack = 1'b0; feat_vote = '0;
    forever begin
      @(negedge clk_fpga);
      feat_ack = 1'b0;
      if (prev_ack) check("feat_req_gap", 32'(feat_req), 0);
      prev_ack = 1'b0;
      if (stale_req != stale_seen) begin
        stale_seen++;
        feat_ack  = 1'b1;
        feat_vote = 16'h0100;
      end else if (feat_req && vote_q.size() > 0) begin
        if (wait_cnt < delay_q[0]) begin
          wait_cnt++;
        end else begin
          feat_ack  = 1'b1;
          feat_vote = vote_q.pop_front();
          void'(delay_q.pop_front());
          feat_log.push_back(int'(feat_addr));
          wait_cnt  = 0;
          prev_ack  = 1'b1;
        end
      end
    end
  end

  int exp_rd[$];
  int exp_ft[$];

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'hBEEF;
  endtask

  task automatic load_hdr(input int addr, input int c, input logic [15:0] thr);
    rom[12'(addr)]     = 16'(c);
    rom[12'(addr + 1)] = thr;
  endtask

  task automatic push_vote(input logic [15:0] v, input int d);
    vote_q.push_back(v);
    delay_q.push_back(d);
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  // Drives one window and follows it to its candidate beat or back to idle.
  task automatic run_window(input string tag, input logic [11:0] x, input logic [11:0] y,
                            input logic [3:0] s, input bit exp_pass, input int exp_exit,
                            input int exp_lat);
    bit got;
    bit done;
    int cycles;
    rd_log.delete();
    feat_log.delete();
    @(negedge clk_fpga);
    check({tag, "_ready_idle"}, 32'(win_ready), 1);
    win_valid = 1'b1; win_xcoord = x; win_ycoord = y; win_scale = s;
    @(negedge clk_fpga);
    win_valid = 1'b0;
    cycles = 1; got = 1'b0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (cand_valid) begin
        got = 1'b1; done = 1'b1;
      end else if (win_ready) begin
        done = 1'b1;
      end else begin
        @(negedge clk_fpga);
        cycles++;
      end
    end
    check({tag, "_finished"}, 32'(done), 1);
`ifdef REJECT_REPORT_EN
    check({tag, "_beat"}, 32'(got), 1);
    if (got) begin
      check({tag, "_pass"}, 32'(cand_pass), 32'(exp_pass));
      check({tag, "_exit"}, 32'(cand_exit_stage), 32'(exp_exit));
    end
`else
    check({tag, "_beat"}, 32'(got), 32'(exp_pass));
`endif
    if (got) begin
      check({tag, "_fields"}, {8'd0, cand_xcoord, cand_ycoord, cand_scale}, {8'd0, x, y, s});
      if (exp_pass && exp_lat > 0) check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
      for (int k = 0; k < 5; k++) begin
        @(negedge clk_fpga);
        check($sformatf("%s_hold%0d", tag, k),
              {2'd0, cand_valid, win_ready, cand_xcoord, cand_ycoord, cand_scale},
              {2'd0, 1'b1, 1'b0, x, y, s});
      end
      cand_ready = 1'b1;
      @(negedge clk_fpga);
      cand_ready = 1'b0;
      check({tag, "_release"}, {30'd0, cand_valid, win_ready}, 32'b01);
    end
  endtask

  initial begin
    reset_fpga = 1'b0; win_valid = 1'b0; win_xcoord = '0; win_ycoord = '0; win_scale = '0;
    cand_ready = 1'b0;
    clear_rom();
    #1;
    check("rst_ctrl", {28'd0, win_ready, rom_rd, feat_req, cand_valid}, 32'b1000);
    check("rst_addr", {8'd0, rom_addr, feat_addr}, 0);
    check("rst_cand", {4'd0, cand_xcoord, cand_ycoord, cand_scale}, 0);
    repeat (2) @(negedge clk_fpga);
    reset_fpga = 1'b1;

    // Stage 0 {2,10} votes 6+5=11 pass; stages 1,2 empty with threshold 0.
    load_hdr(0, 2, 16'd10); load_hdr(38, 0, 16'd0); load_hdr(40, 0, 16'd0);
    push_vote(16'd6, 0); push_vote(16'd5, 1);
    run_window("pass", 12'd37, 12'd20, 4'd2, 1'b1, 2, 32);
    exp_rd = '{0, 1, 38, 39, 40, 41}; check_q("pass_rd", rd_log, exp_rd);
    exp_ft = '{2, 20};                check_q("pass_ft", feat_log, exp_ft);

    // 6+3=9 < 10: rejected in stage 0.
    push_vote(16'd6, 0); push_vote(16'd3, 2);
    run_window("rej0", 12'd5, 12'd6, 4'd1, 1'b0, 0, -1);
    exp_rd = '{0, 1}; check_q("rej0_rd", rd_log, exp_rd);

    // Stage 1 at 38 {1,5} vote 4 fails; stage 2 header must never be read.
    clear_rom();
    load_hdr(0, 2, 16'd10); load_hdr(38, 1, 16'd5); load_hdr(76, 0, 16'd0);
    push_vote(16'd6, 0); push_vote(16'd5, 0); push_vote(16'd4, 0);
    run_window("rej1", 12'd100, 12'd200, 4'd3, 1'b0, 1, -1);
    exp_rd = '{0, 1, 38, 39}; check_q("rej1_rd", rd_log, exp_rd);
    exp_ft = '{2, 20, 40};    check_q("rej1_ft", feat_log, exp_ft);

    // Empty stages with threshold 0 pass at minimum latency 3*9+1.
    clear_rom();
    load_hdr(0, 0, 16'd0); load_hdr(2, 0, 16'd0); load_hdr(4, 0, 16'd0);
    run_window("c0pass", 12'd7, 12'd8, 4'd9, 1'b1, 2, 28);
    exp_rd = '{0, 1, 2, 3, 4, 5}; check_q("c0pass_rd", rd_log, exp_rd);
    load_hdr(0, 0, 16'd1);
    run_window("c0rej", 12'd9, 12'd10, 4'd4, 1'b0, 0, -1);

    // Positive saturation: 3 x 0x7FFF clamps at 32767 >= 32767.
    clear_rom();
    load_hdr(0, 3, 16'h7FFF); load_hdr(56, 0, 16'd0); load_hdr(58, 0, 16'd0);
    push_vote(16'h7FFF, 0); push_vote(16'h7FFF, 0); push_vote(16'h7FFF, 1);
    run_window("satpos", 12'd11, 12'd12, 4'd5, 1'b1, 2, -1);
    exp_ft = '{2, 20, 38}; check_q("satpos_ft", feat_log, exp_ft);

    // Negative saturation: 2 x 0x8000 clamps at -32768 < -32767.
    clear_rom();
    load_hdr(0, 2, 16'h8001); load_hdr(38, 0, 16'd0); load_hdr(40, 0, 16'd0);
    push_vote(16'h8000, 0); push_vote(16'h8000, 0);
    run_window("satneg", 12'd13, 12'd14, 4'd6, 1'b0, 0, -1);

    // Reset while a feature request is outstanding.
    clear_rom();
    load_hdr(0, 2, 16'd10); load_hdr(38, 0, 16'd0); load_hdr(40, 0, 16'd0);
    @(negedge clk_fpga);
    win_valid = 1'b1; win_xcoord = 12'd50; win_ycoord = 12'd60; win_scale = 4'd7;
    @(negedge clk_fpga);
    win_valid = 1'b0;
    for (int i = 0; i < 100 && !feat_req; i++) @(negedge clk_fpga);
    check("rst_mid_in_req", 32'(feat_req), 1);
    reset_fpga = 1'b0;
    #1;
    check("rst_mid_ctrl", {28'd0, win_ready, rom_rd, feat_req, cand_valid}, 32'b1000);
    check("rst_mid_addr", {8'd0, rom_addr, feat_addr}, 0);
    check("rst_mid_cand", {4'd0, cand_xcoord, cand_ycoord, cand_scale}, 0);
    @(negedge clk_fpga);
    reset_fpga = 1'b1;
    stale_req++;
    repeat (3) @(negedge clk_fpga);
    push_vote(16'd6, 0); push_vote(16'd3, 0);
    run_window("post_rst", 12'd1, 12'd2, 4'd3, 1'b0, 0, -1);
    exp_rd = '{0, 1}; check_q("post_rst_rd", rd_log, exp_rd);
    exp_ft = '{2, 20}; check_q("post_rst_ft", feat_log, exp_ft);

    repeat (2) @(negedge clk_fpga);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/haar_cascade_sequencer.md
Name: haar_cascade_sequencer

Overview:
- Multi-stage Haar cascade controller for one detection window at a time. Supersedes the fixed three-stage cascade wrapper.
- Accepts a window (x, y, scale) over valid/ready and walks NUM_STAGES stages, reading stage headers from a packed classifier ROM.
- Issues one request per weak classifier to an external feature evaluator and accumulates the returned votes.
- Rejects the window early on the first failing stage. Emits a candidate beat only for windows that pass every stage.

Parameters:
- DATA_WIDTH_12, 12, coordinate width
- DATA_WIDTH_16, 16, ROM word and vote width (signed votes)
- SCALE_WIDTH, 4, scale index width
- NUM_STAGES, 3, cascade stages evaluated, 1..255
- NUM_PARAM_PER_CLASSIFIER, 18, ROM words per classifier record
- ROM_ADDR_WIDTH, 12, classifier ROM address width
- ROM_LATENCY, 1, cycles from rom_rd to rom_data valid, 1..4
- ACC_WIDTH, 24, signed stage accumulator width

Ports:
- clk_fpga  in  1  clock
- reset_fpga  in  1  asynchronous active-low reset
- win_valid  in  1  window request valid
- win_ready  out  1  window request ready
- win_xcoord  in  DATA_WIDTH_12  window x
- win_ycoord  in  DATA_WIDTH_12  window y
- win_scale  in  SCALE_WIDTH  window scale index
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ROM_ADDR_WIDTH  ROM word address
- rom_data  in  DATA_WIDTH_16  ROM read data
- feat_req  out  1  feature evaluation request
- feat_addr  out  ROM_ADDR_WIDTH  base address of classifier record
- feat_ack  in  1  vote valid, single-cycle pulse
- feat_vote  in  DATA_WIDTH_16  signed weak-classifier vote
- cand_valid  out  1  candidate valid
- cand_ready  in  1  candidate accepted
- cand_xcoord  out  DATA_WIDTH_12  candidate x
- cand_ycoord  out  DATA_WIDTH_12  candidate y
- cand_scale  out  SCALE_WIDTH  candidate scale

Behaviour:
- Reset: all outputs 0 except win_ready=1. FSM goes to IDLE, all registers clear.
- Reset mid-operation aborts the window. The pending feat_ack and any pending ROM data are ignored.
- ROM layout per stage, starting at address 0:
  - word0 = classifier count c (unsigned)
  - word1 = stage threshold (signed)
  - then c records of NUM_PARAM_PER_CLASSIFIER words each
  - next stage base = base + 2 + c*NUM_PARAM_PER_CLASSIFIER, truncated to ROM_ADDR_WIDTH (wraps)
- FSM states:
  - IDLE: win_ready=1. On win_valid, latch coords and scale, set stage=0, base=0, go RD_CNT.
  - RD_CNT: rom_rd=1 for one cycle at base. Wait ROM_LATENCY cycles, latch c, go RD_THR.
  - RD_THR: same timing at base+1. Latch threshold, clear acc, idx=0. Go FEAT_REQ if c>0, else DECIDE.
  - FEAT_REQ: feat_req=1 with feat_addr = base+2+idx*NUM_PARAM_PER_CLASSIFIER. Held high until feat_ack; a same-cycle ack is allowed.
  - On ack: acc += sign-extended vote, saturating at ACC_WIDTH limits; idx++. Go DECIDE when idx==c, else stay in FEAT_REQ.
  - feat_req drops for one cycle between requests.
  - DECIDE (1 cycle): pass iff acc >= sign-extended threshold.
    - Fail: go IDLE with no output.
    - Pass and stage==NUM_STAGES-1: go OUT.
    - Otherwise stage++, base=next base, go RD_CNT.
  - OUT: cand_valid=1 with latched fields, stable until cand_ready, then go IDLE.
- feat_ack outside FEAT_REQ is ignored.
- win_ready is 0 in every state except IDLE. There is no window buffering.
- Minimum latency per stage is 2*(ROM_LATENCY+1)+1 cycles plus the vote cycles. Window accept to cand_valid = that sum over all stages, plus 1.
- c=0: acc=0, so the stage passes iff threshold <= 0.

Optional Feature:
- REJECT_REPORT_EN defined: adds output ports cand_pass (1) and cand_exit_stage (8).
  - Every window produces a cand beat.
  - Failing windows go DECIDE→OUT with cand_pass=0 and cand_exit_stage = failing stage.
  - Passing windows have cand_pass=1 and cand_exit_stage=NUM_STAGES-1.
- Undefined: those ports do not exist and rejected windows produce no beat.

Decomposition:
- Shared package haar_pkg holds:
  - FSM state enum
  - header word offsets (CNT_OFS=0, THR_OFS=1, HDR_WORDS=2)
  - a saturating-add function
- One sub-module, haar_rom_reader: issues rom_rd, counts ROM_LATENCY, returns data with a done pulse. Used by RD_CNT and RD_THR.

Test Plan:
- NUM_STAGES=1, ROM {c=2, thr=10}, votes 6,5 → acc=11 ≥ 10 → cand_valid with x=37, y=20, scale=2. feat_addr sequence 2, 20.
- Same ROM, votes 6,3 → acc=9 → no cand beat, win_ready back to 1.
- NUM_STAGES=3, stage-1 fail → exactly one stage-0 and one stage-1 header read. Stage-1 base = 2+2*18 = 38, no stage-2 ROM reads. With REJECT_REPORT_EN: cand_pass=0, cand_exit_stage=1.
- c=0, thr=0 → pass; thr=1 → reject. Votes of 0x7FFF repeated with ACC_WIDTH=16 → acc saturates at 32767 and does not wrap.
- cand_ready held low 5 cycles → cand fields stable and win_ready=0 throughout. ROM_LATENCY=3 → rom_data is sampled exactly 3 cycles after rom_rd.
- reset_fpga asserted in FEAT_REQ → outputs clear immediately. After release, a new window evaluates from stage 0 and a stale feat_ack is ignored.
